model_loader: RTL and testbench

MODEL_LOADER -- requirements
Module: model_loader

---
 rtl/model_loader_pkg.sv | 34 +++
 rtl/ml_counter.sv | 49 ++++
 rtl/model_loader.sv | 203 ++++++++++++++++++++
 tb/tb_model_loader.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/model_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : model_loader_pkg
//  Description : Shared FSM state type, default configuration constants and
//                a counter-width helper for the model loader.
//  Revision    : 1.0  initial release
// ============================================================================
package model_loader_pkg;

  // Default configuration; the top-level parameters start from these.
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_NUM_CH_IN    = 2;
  localparam int DEF_WEIGHT_W     = 16;
  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_WEIGHT_COUNT = 77;   // 72 kernel + 4 bias + 1 macc_coeff
  localparam int DEF_IMAGE_SIZE   = 25;
  localparam int DEF_NUM_OUT      = 25;

  // Controller states, explicitly 3 bits wide.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } ml_state_t;

  // Bits needed for a counter that must be able to hold max_val itself.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ml_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ml_counter
//  Description : Up-counter with synchronous clear, enable, optional
//                saturation at TERM, and two terminal-count flags:
//                  at_term  - count currently equals TERM
//                  hit_term - this cycle's increment lands on TERM
//  Revision    : 1.0  initial release
// ============================================================================
module ml_counter
  import model_loader_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TERM     = 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             at_term,
  output logic             hit_term
);

  localparam logic [WIDTH-1:0] C_TERM    = WIDTH'(TERM);
  localparam logic [WIDTH-1:0] C_TERM_M1 = WIDTH'(TERM - 1);
  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);

  logic w_step;

  assign at_term  = (count == C_TERM);
  // A saturating counter refuses to step once it sits on TERM.
  assign w_step   = enable && !(SATURATE && at_term);
  assign hit_term = w_step && (count == C_TERM_M1);

  // Count register: clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (w_step) begin
      count <= count + C_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/model_loader.sv
`default_nettype none
// ============================================================================
//  Module      : model_loader
//  Description : Sequences one inference job: streams WEIGHT_COUNT weights
//                into the model's weight memory, then IMAGE_SIZE pixels into
//                the model input (throttled by the output FIFO), then waits
//                for NUM_OUT model outputs before pulsing done.
//  Options     : `define MODEL_LOADER_CHECKSUM_EN adds weight_checksum, the
//                modulo-2^WEIGHT_W sum of every weight written.
//  Revision    : 1.0  initial release
// ============================================================================
module model_loader
  import model_loader_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int NUM_CH_IN    = DEF_NUM_CH_IN,
  parameter int WEIGHT_W     = DEF_WEIGHT_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int WEIGHT_COUNT = DEF_WEIGHT_COUNT,
  parameter int IMAGE_SIZE   = DEF_IMAGE_SIZE,
  parameter int NUM_OUT      = DEF_NUM_OUT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [WEIGHT_W-1:0]           w_s_data,
  input  logic                          w_s_valid,
  output logic                          w_s_ready,
  input  logic [DATA_W*NUM_CH_IN-1:0]   px_s_data,
  input  logic                          px_s_valid,
  output logic                          px_s_ready,
  input  logic                          fifo_almost_full,
  input  logic                          o_valid_mon,
  output logic                          weight_wr_en,
  output logic [ADDR_W-1:0]             weight_wr_addr,
  output logic [WEIGHT_W-1:0]           weight_wr_data,
  output logic [DATA_W*NUM_CH_IN-1:0]   i_data,
  output logic                          i_valid,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_OUT+1)-1:0]  out_count
`ifdef MODEL_LOADER_CHECKSUM_EN
  ,
  output logic [WEIGHT_W-1:0]           weight_checksum
`endif
);

  localparam int W_CNT_W = cnt_width(WEIGHT_COUNT);
  localparam int P_CNT_W = cnt_width(IMAGE_SIZE);
  localparam int O_CNT_W = $clog2(NUM_OUT + 1);

  ml_state_t          r_state;
  ml_state_t          w_next_state;

  logic               w_start_go;
  logic               w_w_accept;
  logic               w_p_accept;
  logic               w_o_en;

  logic [W_CNT_W-1:0] w_w_cnt;
  logic               w_w_full;
  logic               w_w_last;
  logic [P_CNT_W-1:0] w_unused_px_cnt;
  logic               w_p_full;
  logic               w_p_last;
  logic               w_o_full;
  logic               w_o_hit;

  // start is only honoured in IDLE, and abort overrides it.
  assign w_start_go = (r_state == IDLE) && start && !abort;
  assign w_w_accept = w_s_valid && w_s_ready;
  assign w_p_accept = px_s_valid && px_s_ready;
  // Outputs are only counted while a job is in flight; an aborting cycle
  // leaves the count untouched.
  assign w_o_en     = o_valid_mon && busy && !abort;

  // Weight accept counter; its value is the write address of each accept.
  ml_counter #(
    .WIDTH    (W_CNT_W),
    .TERM     (WEIGHT_COUNT),
    .SATURATE (1'b0)
  ) u_weight_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_start_go),
    .enable   (w_w_accept),
    .count    (w_w_cnt),
    .at_term  (w_w_full),
    .hit_term (w_w_last)
  );

  // Pixel accept counter.
  ml_counter #(
    .WIDTH    (P_CNT_W),
    .TERM     (IMAGE_SIZE),
    .SATURATE (1'b0)
  ) u_pixel_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_start_go),
    .enable   (w_p_accept),
    .count    (w_unused_px_cnt),
    .at_term  (w_p_full),
    .hit_term (w_p_last)
  );

  // Model output counter, saturating at NUM_OUT.
  ml_counter #(
    .WIDTH    (O_CNT_W),
    .TERM     (NUM_OUT),
    .SATURATE (1'b1)
  ) u_out_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_start_go),
    .enable   (w_o_en),
    .count    (out_count),
    .at_term  (w_o_full),
    .hit_term (w_o_hit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and state-derived handshake/status outputs.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    w_s_ready    = 1'b0;
    px_s_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        // The full flag is a guard only; LOAD is left on the last accept.
        w_s_ready = !abort && !w_w_full;
        if (w_w_last) w_next_state = STREAM;
      end
      STREAM: begin
        busy       = 1'b1;
        px_s_ready = !abort && !fifo_almost_full && !w_p_full;
        if (w_p_last) w_next_state = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Leave as soon as the final output lands, even this very cycle.
        if (w_o_full || w_o_hit) w_next_state = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    if (abort) w_next_state = IDLE;
  end

  // One-cycle registered forwarding of accepted weights and pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_wr_en   <= 1'b0;
      weight_wr_addr <= '0;
      weight_wr_data <= '0;
      i_valid        <= 1'b0;
      i_data         <= '0;
    end else begin
      weight_wr_en <= w_w_accept;
      i_valid      <= w_p_accept;
      if (w_w_accept) begin
        weight_wr_addr <= ADDR_W'(w_w_cnt);
        weight_wr_data <= w_s_data;
      end
      if (w_p_accept) begin
        i_data <= px_s_data;
      end
    end
  end

`ifdef MODEL_LOADER_CHECKSUM_EN
  // Running sum of the words actually written to the model, restarted per job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_checksum <= '0;
    end else if (w_start_go) begin
      weight_checksum <= '0;
    end else if (weight_wr_en) begin
      weight_checksum <= weight_checksum + weight_wr_data;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_model_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_model_loader
//  Description : Self-checking bench for model_loader. A transaction-level
//                model (accept counters, expected-write indices, output pulse
//                tally) predicts every write, pixel, ready, busy/done and
//                out_count value cycle by cycle under random stimulus.
//  Options     : MODEL_LOADER_CHECKSUM_EN also checks weight_checksum.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_model_loader;

  localparam int DATA_W       = 8;
  localparam int NUM_CH_IN    = 2;
  localparam int WEIGHT_W     = 16;
  localparam int ADDR_W       = 32;
  localparam int WEIGHT_COUNT = 77;
  localparam int IMAGE_SIZE   = 25;
  localparam int NUM_OUT      = 25;
  localparam int PX_W         = DATA_W * NUM_CH_IN;
  localparam int OC_W         = $clog2(NUM_OUT + 1);

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                abort;
  logic [WEIGHT_W-1:0] w_s_data;
  logic                w_s_valid;
  logic                w_s_ready;
  logic [PX_W-1:0]     px_s_data;
  logic                px_s_valid;
  logic                px_s_ready;
  logic                fifo_almost_full;
  logic                o_valid_mon;
  logic                weight_wr_en;
  logic [ADDR_W-1:0]   weight_wr_addr;
  logic [WEIGHT_W-1:0] weight_wr_data;
  logic [PX_W-1:0]     i_data;
  logic                i_valid;
  logic                busy;
  logic                done;
  logic [OC_W-1:0]     out_count;
`ifdef MODEL_LOADER_CHECKSUM_EN
  logic [WEIGHT_W-1:0] weight_checksum;
`endif

  int total = 0;
  int bad   = 0;

  logic [WEIGHT_W-1:0] wts [WEIGHT_COUNT];
  logic [PX_W-1:0]     pix [IMAGE_SIZE];

  always #5 clk = ~clk;

  model_loader #(
    .DATA_W       (DATA_W),
    .NUM_CH_IN    (NUM_CH_IN),
    .WEIGHT_W     (WEIGHT_W),
    .ADDR_W       (ADDR_W),
    .WEIGHT_COUNT (WEIGHT_COUNT),
    .IMAGE_SIZE   (IMAGE_SIZE),
    .NUM_OUT      (NUM_OUT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .w_s_data         (w_s_data),
    .w_s_valid        (w_s_valid),
    .w_s_ready        (w_s_ready),
    .px_s_data        (px_s_data),
    .px_s_valid       (px_s_valid),
    .px_s_ready       (px_s_ready),
    .fifo_almost_full (fifo_almost_full),
    .o_valid_mon      (o_valid_mon),
    .weight_wr_en     (weight_wr_en),
    .weight_wr_addr   (weight_wr_addr),
    .weight_wr_data   (weight_wr_data),
    .i_data           (i_data),
    .i_valid          (i_valid),
    .busy             (busy),
    .done             (done),
    .out_count        (out_count)
`ifdef MODEL_LOADER_CHECKSUM_EN
    ,
    .weight_checksum  (weight_checksum)
`endif
  );

  task automatic idle_inputs();
    start = 0; abort = 0; w_s_valid = 0; px_s_valid = 0;
    fifo_almost_full = 0; o_valid_mon = 0;
    w_s_data = '0; px_s_data = '0;
  endtask

  // Reset held: everything zero even with traffic offered; after release the
  // block sits idle and ignores valids and output pulses.
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    w_s_valid = 1; px_s_valid = 1; o_valid_mon = 1;
    w_s_data = 16'hBEEF; px_s_data = 16'h1234;
    repeat (3) @(negedge clk);
    total++;
    if ({weight_wr_en, i_valid, busy, done, w_s_ready, px_s_ready} !== 6'b0 ||
        weight_wr_addr !== '0 || weight_wr_data !== '0 || i_data !== '0 || out_count !== '0) begin
      bad++;
      $display("FAIL reset_held: en=%b iv=%b busy=%b done=%b wr=%b pr=%b addr=%h data=%h idata=%h oc=%0d want all 0",
               weight_wr_en, i_valid, busy, done, w_s_ready, px_s_ready, weight_wr_addr,
               weight_wr_data, i_data, out_count);
    end
    rst_n = 1;
    repeat (3) @(negedge clk);
    total++;
    if ({weight_wr_en, i_valid, busy, done, w_s_ready, px_s_ready} !== 6'b0 || out_count !== '0) begin
      bad++;
      $display("FAIL reset_idle: en=%b iv=%b busy=%b done=%b wr=%b pr=%b oc=%0d want all 0",
               weight_wr_en, i_valid, busy, done, w_s_ready, px_s_ready, out_count);
    end
    idle_inputs();
  endtask

  // One full job. ovm_mode: 0 = output pulse with every pixel accept,
  // 1 = random pulses during weight load only, 2 = random pulses once pixels
  // start, continuing into drain.
  task automatic test_frame(input string name, input int w_gap, input int p_gap,
                            input int fam_at, input int fam_len, input bit fam_rand,
                            input int ovm_mode, input int ovm_total);
    int  wk, pk, pulses, ph, phase, fam_left, e_cyc, p_cyc, d_cyc;
    int  exp_waddr, exp_pidx;
    bit  exp_wen, exp_iv, exp_done, exp_busy, fam_done, finished, p_hs;
    logic [OC_W-1:0]     exp_oc;
    logic [WEIGHT_W-1:0] sum;
    @(negedge clk);
    idle_inputs();
    start = 1;
    @(negedge clk);
    start = 0;
    phase = 1; wk = 0; pk = 0; pulses = 0; fam_left = 0; fam_done = 0;
    e_cyc = -1; p_cyc = -1; d_cyc = -1; exp_wen = 0; exp_iv = 0;
    exp_waddr = 0; exp_pidx = 0; finished = 0;
    for (int i = 0; i < 3000 && !finished; i++) begin
      if (i > 0) @(negedge clk);
      // --- check results of the previous edge ---
      total++;
      if (weight_wr_en !== exp_wen ||
          (exp_wen && (weight_wr_addr !== ADDR_W'(exp_waddr) || weight_wr_data !== wts[exp_waddr]))) begin
        bad++;
        $display("FAIL %s weight_write cyc=%0d: en=%b addr=%0d data=%h want en=%b addr=%0d data=%h",
                 name, i, weight_wr_en, weight_wr_addr, weight_wr_data, exp_wen, exp_waddr, wts[exp_waddr]);
      end
      total++;
      if (i_valid !== exp_iv || (exp_iv && i_data !== pix[exp_pidx])) begin
        bad++;
        $display("FAIL %s pixel_out cyc=%0d: iv=%b data=%h want iv=%b data=%h",
                 name, i, i_valid, i_data, exp_iv, pix[exp_pidx]);
      end
      exp_oc = OC_W'((pulses > NUM_OUT) ? NUM_OUT : pulses);
      total++;
      if (out_count !== exp_oc) begin
        bad++;
        $display("FAIL %s out_count cyc=%0d: got %0d want %0d", name, i, out_count, exp_oc);
      end
      exp_done = (d_cyc >= 0) && (i == d_cyc + 1);
      exp_busy = !((d_cyc >= 0) && (i > d_cyc));
      total++;
      if (done !== exp_done || busy !== exp_busy) begin
        bad++;
        $display("FAIL %s status cyc=%0d: busy=%b done=%b want busy=%b done=%b",
                 name, i, busy, done, exp_busy, exp_done);
      end
`ifdef MODEL_LOADER_CHECKSUM_EN
      if (exp_done) begin
        sum = '0;
        foreach (wts[k]) sum += wts[k];
        total++;
        if (weight_checksum !== sum) begin
          bad++;
          $display("FAIL %s checksum: got %h want %h", name, weight_checksum, sum);
        end
      end
`endif
      if ((d_cyc >= 0) && (i == d_cyc + 2)) begin
        finished = 1;
      end else begin
        // --- drive this cycle ---
        ph = phase;
        exp_wen = 0; exp_iv = 0; p_hs = 0;
        start = (d_cyc < 0) && ($urandom_range(7) == 0);
        abort = 0;
        if (ph == 2 && pk == fam_at && !fam_done) begin
          fam_left = fam_len; fam_done = 1;
        end
        fifo_almost_full = (fam_left > 0) ? 1'b1 : (fam_rand && $urandom_range(4) == 0);
        if (fam_left > 0) fam_left--;
        w_s_valid  = (ph == 1) ? ($urandom_range(99) >= w_gap) : ($urandom_range(1) == 1);
        w_s_data   = (ph == 1) ? wts[wk] : WEIGHT_W'($urandom);
        px_s_valid = (ph == 2) ? ($urandom_range(99) >= p_gap) : ($urandom_range(1) == 1);
        px_s_data  = (ph == 2) ? pix[pk] : PX_W'($urandom);
        #1;
        total++;
        if (w_s_ready !== (ph == 1) || px_s_ready !== (ph == 2 && !fifo_almost_full)) begin
          bad++;
          $display("FAIL %s ready cyc=%0d: w_s_ready=%b px_s_ready=%b want %b %b",
                   name, i, w_s_ready, px_s_ready, (ph == 1), (ph == 2 && !fifo_almost_full));
        end
        if (ph == 1 && w_s_valid) begin
          exp_wen = 1; exp_waddr = wk; wk++;
          if (wk == WEIGHT_COUNT) phase = 2;
        end
        if (ph == 2 && px_s_valid && !fifo_almost_full) begin
          exp_iv = 1; exp_pidx = pk; pk++; p_hs = 1;
          if (pk == IMAGE_SIZE) begin phase = 3; e_cyc = i; end
        end
        case (ovm_mode)
          0:       o_valid_mon = p_hs;
          1:       o_valid_mon = (ph == 1) && (pulses < ovm_total) && ($urandom_range(3) != 0);
          default: o_valid_mon = (ph >= 2) && (pulses < ovm_total) && ($urandom_range(2) == 0);
        endcase
        if (o_valid_mon) begin
          pulses++;
          if (pulses == NUM_OUT) p_cyc = i;
        end
        if (d_cyc < 0 && e_cyc >= 0 && p_cyc >= 0)
          d_cyc = (p_cyc > e_cyc) ? p_cyc : e_cyc + 1;
      end
    end
    if (!finished) begin
      total++; bad++;
      $display("FAIL %s timeout: weights=%0d pixels=%0d pulses=%0d", name, wk, pk, pulses);
    end
    idle_inputs();
  endtask

  // Abort during weight load drops everything next cycle and holds out_count;
  // abort also beats a simultaneous start in IDLE.
  task automatic test_abort();
    @(negedge clk);
    idle_inputs();
    start = 1; abort = 1;
    @(negedge clk);
    idle_inputs();
    w_s_valid = 1;
    #1;
    total++;
    if (busy !== 1'b0 || w_s_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_beats_start: busy=%b w_s_ready=%b want 0 0", busy, w_s_ready);
    end
    w_s_valid = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) @(negedge clk);
      if (i > 0) begin
        total++;
        if (weight_wr_en !== 1'b1 || weight_wr_addr !== ADDR_W'(i - 1) || weight_wr_data !== wts[i - 1]) begin
          bad++;
          $display("FAIL abort_preload cyc=%0d: en=%b addr=%0d data=%h want 1 %0d %h",
                   i, weight_wr_en, weight_wr_addr, weight_wr_data, i - 1, wts[i - 1]);
        end
      end
      w_s_valid = 1;
      w_s_data  = wts[i];
      o_valid_mon = (i < 40) && (i % 2 == 0);
      abort = (i == 40);
    end
    @(negedge clk);
    abort = 0; o_valid_mon = 1;
    total++;
    if (weight_wr_en !== 1'b0 || busy !== 1'b0 || w_s_ready !== 1'b0 || out_count !== OC_W'(20)) begin
      bad++;
      $display("FAIL abort_next: en=%b busy=%b w_s_ready=%b oc=%0d want 0 0 0 20",
               weight_wr_en, busy, w_s_ready, out_count);
    end
    repeat (3) @(negedge clk);
    total++;
    if (weight_wr_en !== 1'b0 || w_s_ready !== 1'b0 || out_count !== OC_W'(20)) begin
      bad++;
      $display("FAIL abort_hold: en=%b w_s_ready=%b oc=%0d want 0 0 20", weight_wr_en, w_s_ready, out_count);
    end
    idle_inputs();
  endtask

  // Asynchronous reset in the middle of pixel streaming.
  task automatic test_reset_mid_stream();
    int ivs;
    ivs = 0;
    @(negedge clk);
    idle_inputs();
    start = 1;
    @(negedge clk);
    start = 0;
    w_s_valid = 1; px_s_valid = 1; o_valid_mon = 1;
    for (int i = 0; i < 300 && ivs < 5; i++) begin
      w_s_data  = WEIGHT_W'($urandom) | 16'h1;
      px_s_data = PX_W'($urandom) | 16'h1;
      @(negedge clk);
      if (i_valid === 1'b1) ivs++;
    end
    total++;
    if (ivs < 5) begin
      bad++;
      $display("FAIL mid_stream_reach: pixels seen %0d want 5", ivs);
    end
    #2 rst_n = 0;
    #1;
    total++;
    if ({weight_wr_en, i_valid, busy, done, w_s_ready, px_s_ready} !== 6'b0 ||
        weight_wr_addr !== '0 || weight_wr_data !== '0 || i_data !== '0 || out_count !== '0) begin
      bad++;
      $display("FAIL reset_mid_stream: en=%b iv=%b busy=%b done=%b wr=%b pr=%b addr=%h data=%h idata=%h oc=%0d want all 0",
               weight_wr_en, i_valid, busy, done, w_s_ready, px_s_ready, weight_wr_addr,
               weight_wr_data, i_data, out_count);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    for (int k = 0; k < WEIGHT_COUNT; k++)
      wts[k] = (k < 72) ? 16'd1 : (k < 76) ? 16'd10 : 16'h0100;
    for (int k = 0; k < IMAGE_SIZE; k++) pix[k] = 16'd100;

    test_reset();
    test_frame("weights_and_pixels", 0, 0, -1, 0, 1'b0, 0, NUM_OUT);
    test_frame("fifo_backpressure", 0, 0, 10, 5, 1'b0, 2, NUM_OUT);

    for (int k = 0; k < WEIGHT_COUNT; k++) wts[k] = WEIGHT_W'($urandom);
    for (int k = 0; k < IMAGE_SIZE; k++) pix[k] = PX_W'($urandom);
    test_frame("random_gaps", 30, 30, -1, 0, 1'b1, 2, NUM_OUT);
    test_frame("saturate_in_load", 20, 20, -1, 0, 1'b1, 1, 30);

    test_abort();
    test_frame("reload_after_abort", 10, 10, -1, 0, 1'b1, 0, NUM_OUT);

    test_reset_mid_stream();
    test_frame("frame_after_reset", 0, 15, 3, 4, 1'b1, 2, NUM_OUT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
